// File: rtl/data_sram_bridge.sv
// Bridges the CPU byte-masked data-SRAM port onto a word-wide DataMem that has one write enable.
// Sub-word stores become a stalled read-modify-write. Sticky error and traffic counters are kept for debug.
module data_sram_bridge #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_sram_en,
    input  logic [3:0]       data_sram_wen,
    input  logic [31:0]      data_sram_addr,
    input  logic [31:0]      data_sram_wdata,
    output logic [31:0]      data_sram_rdata,
    output logic             stall,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             err_mask,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rmw_cnt
);

    typedef enum logic {IDLE, MERGE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      word_q, word_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rmw_cnt_q, rmw_cnt_d;

    logic [31:0] req_addr;
    logic [31:0] merged;
    logic        is_read, is_full, is_part;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req_addr        = data_sram_addr & 32'hFFFF_FFFC;
    assign data_sram_rdata = mem_rdata;
    assign err_mask        = err_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;
    assign rmw_cnt         = rmw_cnt_q;

    always_comb begin
        is_read = (data_sram_wen == 4'h0);
        is_full = (data_sram_wen == 4'hF);
        case (data_sram_wen)
            4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC: is_part = 1'b1;
            default:                            is_part = 1'b0;
        endcase
        merged = mem_rdata;
        for (int k = 0; k < 4; k++) begin
            if (data_sram_wen[k]) merged[8*k +: 8] = data_sram_wdata[8*k +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        word_d    = word_q;
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        rmw_cnt_d = rmw_cnt_q;
        mem_we    = 1'b0;
        stall     = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = data_sram_wdata;
        case (state_q)
            IDLE: begin
                if (data_sram_en) begin
                    if (is_read) begin
                        rd_cnt_d = sat_inc(rd_cnt_q);
                    end else if (is_full) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = sat_inc(wr_cnt_q);
                    end else if (is_part) begin
                        stall   = 1'b1;
                        addr_d  = req_addr;
                        word_d  = merged;
                        state_d = MERGE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MERGE: begin
                // Commit from captured state only; whatever the CPU drives now is ignored.
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = word_q;
                rmw_cnt_d = sat_inc(rmw_cnt_q);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            mem_we = 1'b0;
            stall  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            word_q    <= '0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rmw_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            word_q    <= word_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            rmw_cnt_q <= rmw_cnt_d;
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Bench for data_sram_bridge: directed vector table, hand sequences, then random traffic vs. a word-level model.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        stall, mem_we, err_mask;
    logic [15:0] rd_cnt, wr_cnt, rmw_cnt;

    logic [31:0] rdata2, mem_addr2, mem_wdata2;
    logic        stall2, mem_we2, err_mask2;
    logic [1:0]  rd_cnt2, wr_cnt2, rmw_cnt2;

    logic [31:0] mem [64] = '{default: 32'h0};

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    data_sram_bridge #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata),
        .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err_mask(err_mask),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .rmw_cnt(rmw_cnt)
    );

    data_sram_bridge #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
        .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata2),
        .stall(stall2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata), .err_mask(err_mask2),
        .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2), .rmw_cnt(rmw_cnt2)
    );

    typedef struct {
        logic        r, e;
        logic [3:0]  w;
        logic [31:0] a, d;
        logic        es, ewe;
        logic [31:0] ewd;
        logic        crd;
        logic [31:0] erd;
    } vec_t;

    int n_chk = 0, n_fail = 0;

    // Reference model: word memory, a pending merged store, and unbounded event counts.
    logic [31:0] m_mem [64] = '{default: 32'h0};
    logic        m_pend = 1'b0;
    logic [31:0] m_addr = '0, m_word = '0;
    int          m_rd = 0, m_wr = 0, m_rmw = 0;
    logic        m_err = 1'b0;
    bit          rst_seen = 1'b0;

    function automatic vec_t mk(logic r, logic e, logic [3:0] w, logic [31:0] a, logic [31:0] d,
                                logic es, logic ewe, logic [31:0] ewd, logic crd, logic [31:0] erd);
        vec_t v;
        v.r = r; v.e = e; v.w = w; v.a = a; v.d = d;
        v.es = es; v.ewe = ewe; v.ewd = ewd; v.crd = crd; v.erd = erd;
        return v;
    endfunction

    function automatic bit legal_part(logic [3:0] w);
        return w == 4'h1 || w == 4'h2 || w == 4'h4 || w == 4'h8 || w == 4'h3 || w == 4'hC;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v, input bit tbl);
        logic        x_we, x_st, x_rd;
        logic [31:0] x_addr, x_wd;
        int          idx;
        rst = v.r; en = v.e; wen = v.w; addr = v.a; wdata = v.d;
        @(negedge clk);
        idx = int'(v.a[7:2]);
        x_we = 1'b0; x_st = 1'b0; x_rd = 1'b0; x_addr = '0; x_wd = '0;
        if (!v.r) begin
            if (m_pend) begin
                x_we = 1'b1; x_addr = m_addr; x_wd = m_word;
            end else if (v.e) begin
                if (v.w == 4'h0) x_rd = 1'b1;
                else if (v.w == 4'hF) begin x_we = 1'b1; x_addr = {v.a[31:2], 2'b00}; x_wd = v.d; end
                else if (legal_part(v.w)) x_st = 1'b1;
            end
        end
        chk("stall", 32'(stall), 32'(x_st));
        chk("mem_we", 32'(mem_we), 32'(x_we));
        if (x_we) begin
            chk("mem_addr", mem_addr, x_addr);
            chk("mem_wdata", mem_wdata, x_wd);
        end
        if (x_rd) chk("rdata", rdata, m_mem[idx]);
        if (rst_seen) begin
            chk("rd_cnt", 32'(rd_cnt), 32'(sat(m_rd, 65535)));
            chk("wr_cnt", 32'(wr_cnt), 32'(sat(m_wr, 65535)));
            chk("rmw_cnt", 32'(rmw_cnt), 32'(sat(m_rmw, 65535)));
            chk("err_mask", 32'(err_mask), 32'(m_err));
            chk("rd_cnt_w2", 32'(rd_cnt2), 32'(sat(m_rd, 3)));
            chk("wr_cnt_w2", 32'(wr_cnt2), 32'(sat(m_wr, 3)));
            chk("rmw_cnt_w2", 32'(rmw_cnt2), 32'(sat(m_rmw, 3)));
        end
        if (tbl) begin
            chk("tbl_stall", 32'(stall), 32'(v.es));
            chk("tbl_we", 32'(mem_we), 32'(v.ewe));
            if (v.ewe) chk("tbl_wdata", mem_wdata, v.ewd);
            if (v.crd) chk("tbl_rdata", rdata, v.erd);
        end
        if (v.r) begin
            m_pend = 1'b0; m_rd = 0; m_wr = 0; m_rmw = 0; m_err = 1'b0; rst_seen = 1'b1;
        end else if (m_pend) begin
            m_mem[int'(m_addr[7:2])] = m_word; m_rmw++; m_pend = 1'b0;
        end else if (v.e) begin
            if (v.w == 4'h0) m_rd++;
            else if (v.w == 4'hF) begin m_mem[idx] = v.d; m_wr++; end
            else if (legal_part(v.w)) begin
                m_word = m_mem[idx];
                for (int k = 0; k < 4; k++) if (v.w[k]) m_word[8*k +: 8] = v.d[8*k +: 8];
                m_addr = {v.a[31:2], 2'b00};
                m_pend = 1'b1;
            end else m_err = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[18];
    logic [3:0] wsel;

    initial begin
        //             rst   en    wen   addr    wdata          stall we    wdata          chkrd rdata
        vecs[0]  = mk(1'b1, 1'b1, 4'hF, 32'h10, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b1, 4'hF, 32'h10, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
        vecs[2]  = mk(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 1'b1, 4'h0, 32'h10, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF);
        vecs[4]  = mk(1'b0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 1'b0, 1'b1, 32'h1122_3344, 1'b0, 32'h0);
        vecs[5]  = mk(1'b0, 1'b1, 4'h2, 32'h21, 32'h0000_AA00, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
        vecs[6]  = mk(1'b0, 1'b1, 4'h2, 32'h21, 32'h0000_AA00, 1'b0, 1'b1, 32'h1122_AA44, 1'b0, 32'h0);
        vecs[7]  = mk(1'b0, 1'b1, 4'h0, 32'h20, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h1122_AA44);
        vecs[8]  = mk(1'b0, 1'b1, 4'hF, 32'h30, 32'h5566_7788, 1'b0, 1'b1, 32'h5566_7788, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b1, 4'hC, 32'h30, 32'hBBCC_0000, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
        vecs[10] = mk(1'b0, 1'b1, 4'h0, 32'h10, 32'h0,         1'b0, 1'b1, 32'hBBCC_7788, 1'b0, 32'h0);
        vecs[11] = mk(1'b0, 1'b1, 4'h0, 32'h30, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hBBCC_7788);
        vecs[12] = mk(1'b0, 1'b1, 4'h5, 32'h40, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
        vecs[13] = mk(1'b0, 1'b0, 4'h0, 32'h40, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
        vecs[14] = mk(1'b0, 1'b1, 4'hF, 32'h40, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0);
        vecs[15] = mk(1'b0, 1'b1, 4'h1, 32'h40, 32'h0000_00FF, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
        vecs[16] = mk(1'b1, 1'b1, 4'h1, 32'h40, 32'h0000_00FF, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
        vecs[17] = mk(1'b0, 1'b1, 4'h0, 32'h40, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A5_A5A5);

        rst = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) step(vecs[i], 1'b1);

        // Aborted merge must leave no trace; err_mask was cleared by the same reset.
        chk("rst_merge_rmw_cnt", 32'(rmw_cnt), 32'h0);
        chk("rst_merge_err", 32'(err_mask), 32'h0);
        chk("rst_merge_rd_cnt", 32'(rd_cnt), 32'h1);

        for (int i = 0; i < 5; i++) step(mk(1'b0, 1'b1, 4'h0, 32'(4 * i), 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0), 1'b0);
        chk("sat_rd_cnt_w2", 32'(rd_cnt2), 32'h3);
        chk("rd_cnt_after_6", 32'(rd_cnt), 32'h6);

        step(mk(1'b0, 1'b1, 4'h6, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0), 1'b0);
        for (int i = 0; i < 3; i++) step(mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0), 1'b0);
        chk("err_sticky", 32'(err_mask), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            wsel = 4'($urandom_range(0, 15));
            step(mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), wsel,
                    32'($urandom_range(0, 255)), $urandom, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
